ue14500_seq: RTL
================

Name: ue14500_seq

Overview:
- Program sequencer for the 1-bit ICU. Sits directly upstream of it.
- Owns the program counter. Drives the program-memory address and presents the fetched opcode nibble to the ICU's IR input. Decodes the operand as the I/O or jump address.
- Consumes the ICU's registered JMP/RTN (and optionally FL0) pulses to redirect flow, using a circular return-address stack.

Parameters:
- ADDR_W, 8: program counter, operand and I/O address width.
- DEPTH, 4: return-stack entries (power of 2, >= 2).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset, asynchronous, active-high.
- MEM_ADDR  out  ADDR_W  program-memory address (= PC).
- MEM_DATA  in  4+ADDR_W  fetched word, combinational from memory. [ADDR_W+3:ADDR_W] is the opcode; [ADDR_W-1:0] is the operand.
- IR_OUT  out  4  opcode to ICU IR_IN.
- IO_ADDR  out  ADDR_W  operand of the current word, combinational, selects the I/O bit.
- JMP  in  1  ICU jump pulse (registered in ICU, one cycle after the JMP opcode).
- RTN  in  1  ICU return pulse (same timing).
- FL0  in  1  ICU NOP0 flag pulse.
- RUN  in  1  resume from halt (optional feature only).
- HALTED  out  1  sequencer halted.
- STK_ERR  out  1  sticky stack overflow/underflow flag.
- STK_CNT  out  clog2(DEPTH)+1  valid stack entries.

Behaviour:
- Reset (async):
  - PC=0, OPR_Q=0, SP=0, STK_CNT=0, STK_ERR=0, HALTED=0.
  - Stack contents need not be cleared.
- Fetch:
  - MEM_ADDR=PC.
  - IR_OUT=MEM_DATA opcode and IO_ADDR=MEM_DATA operand, both combinational.
  - Each posedge: OPR_Q <= operand.
- Default update: PC <= PC+1, wrapping modulo 2^ADDR_W (all-ones -> 0).
- JMP (one branch delay slot):
  - A JMP opcode fetched at address A raises JMP during the cycle with PC=A+1.
  - The word at A+1 is presented to the ICU (delay slot).
  - At that cycle's posedge: PC <= OPR_Q (the JMP operand); push PC+1 (=A+2) at stack[SP]; SP <= SP+1 mod DEPTH; STK_CNT <= min(STK_CNT+1, DEPTH).
  - If STK_CNT was already DEPTH, the oldest entry is overwritten (circular) and STK_ERR <= 1.
- RTN:
  - At posedge with RTN=1: SP <= SP-1 mod DEPTH; PC <= stack[SP-1]; STK_CNT <= STK_CNT-1.
  - The ICU itself skips the delay-slot word. The sequencer does not suppress it.
  - Underflow (STK_CNT==0): PC <= 0, SP and STK_CNT unchanged, STK_ERR <= 1.
- JMP and RTN together (illegal from ICU): JMP takes priority, no pop.
- STK_ERR clears only on RST.
- Reset mid-JMP/RTN: the pulse is discarded; the first fetch after RST release is address 0.

Optional Feature:
- Macro UE14500_SEQ_HALT_EN.
- Defined: an FL0 pulse at a posedge sets HALTED=1, and PC keeps the value it would have taken that edge (normal increment).
  - While HALTED: PC frozen, IR_OUT forced to 4'b0000 (NOP0), which keeps the ICU idle. IO_ADDR still tracks memory. JMP/RTN are ignored; no push or pop.
  - RUN=1 at a posedge clears HALTED; the fetch resumes at the frozen PC on the next cycle. RUN=1 while not halted has no effect.
  - FL0 and RUN at the same edge while halted: RUN wins.
- Undefined: FL0 and RUN ignored, HALTED tied 0, IR_OUT always equals the memory opcode.

Test Plan:
- Reset/increment: release RST, memory all 4'b1010 -> MEM_ADDR runs 0,1,2,…,255,0 (wrap). HALTED=0, STK_CNT=0.
- Jump: word 0x05 = {1100, 0x40}; drive JMP=1 while PC=0x06 -> next PC=0x40, stack top=0x07, STK_CNT=1. The word at 0x06 is presented once.
- Return: after the jump above, pulse RTN while PC=0x41 -> next PC=0x07, STK_CNT=0, STK_ERR=0.
- Overflow/underflow: 5 JMP pulses with DEPTH=4 -> STK_CNT=4, STK_ERR=1, and the first return address is lost. Then 4 RTN pop addresses in reverse push order (pushes 5,4,3,2). A 5th RTN gives PC=0 and STK_ERR stays 1.
- Async reset: assert RST mid-cycle while JMP=1 -> PC=0 immediately, no push, STK_CNT=0.
- Halt (macro on): FL0 pulse at PC=0x10 -> PC frozen at 0x11, IR_OUT=0000, a JMP pulse is ignored. RUN pulse -> MEM_ADDR 0x11, then 0x12. With the macro off, FL0 leaves HALTED=0.

Source files
------------

// File: rtl/ue14500_seq.sv
// ue14500_seq: program sequencer for the 1-bit ICU (PC, fetch/decode, circular return stack).
// Halt/resume on FL0/RUN is built only when UE14500_SEQ_HALT_EN is defined.
module ue14500_seq #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    output logic [ADDR_W-1:0]       MEM_ADDR,
    input  logic [ADDR_W+3:0]       MEM_DATA,
    output logic [3:0]              IR_OUT,
    output logic [ADDR_W-1:0]       IO_ADDR,
    input  logic                    JMP,
    input  logic                    RTN,
    input  logic                    FL0,
    input  logic                    RUN,
    output logic                    HALTED,
    output logic                    STK_ERR,
    output logic [$clog2(DEPTH):0]  STK_CNT
);
    localparam int SP_W  = $clog2(DEPTH);
    localparam int CNT_W = SP_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // state  | meaning
    // S_RUN  | fetching and sequencing normally
    // S_HALT | PC frozen, NOP0 presented to the ICU, JMP/RTN ignored
    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_pc_inc;
    logic [ADDR_W-1:0] r_opr_q;
    logic [SP_W-1:0]   r_sp, w_sp_nxt, w_sp_dec;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt;
    logic              w_push;
    logic [ADDR_W-1:0] r_stk [DEPTH];
    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic              w_fl0, w_run;

`ifdef UE14500_SEQ_HALT_EN
    assign w_fl0 = FL0;
    assign w_run = RUN;
`else
    logic w_unused;
    assign w_fl0    = 1'b0;
    assign w_run    = 1'b0;
    assign w_unused = &{1'b0, FL0, RUN};
`endif

    assign w_opcode  = MEM_DATA[ADDR_W+3:ADDR_W];
    assign w_operand = MEM_DATA[ADDR_W-1:0];
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_sp_dec  = r_sp - SP_W'(1);

    assign MEM_ADDR = r_pc;
    assign IO_ADDR  = w_operand;
    assign IR_OUT   = (r_state == S_HALT) ? 4'b0000 : w_opcode;
    assign HALTED   = (r_state == S_HALT);
    assign STK_ERR  = r_err;
    assign STK_CNT  = r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = w_pc_inc;
        w_sp_nxt    = r_sp;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        case (r_state)
            S_HALT: begin
                w_pc_nxt = r_pc;
                if (w_run) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                // JMP wins over a simultaneous RTN; the ICU should never raise both.
                if (JMP) begin
                    w_pc_nxt = r_opr_q;
                    w_push   = 1'b1;
                    w_sp_nxt = r_sp + SP_W'(1);
                    if (r_cnt == CNT_FULL) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (RTN) begin
                    if (r_cnt == '0) begin
                        w_pc_nxt  = '0;
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pc_nxt  = r_stk[w_sp_dec];
                        w_sp_nxt  = w_sp_dec;
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                if (w_fl0) begin
                    w_state_nxt = S_HALT;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_RUN;
            r_pc    <= '0;
            r_opr_q <= '0;
            r_sp    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_opr_q <= w_operand;
            r_sp    <= w_sp_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Stack storage is not reset; STK_CNT alone says which entries are valid.
    always_ff @(posedge CLK) begin
        if (w_push && !RST) begin
            r_stk[r_sp] <= w_pc_inc;
        end
    end

endmodule
